sr_bank_writer: RTL
===================

// Module: sr_bank_writer
// PURPOSE
//  Write controller for a bank of WIDTH SR flip-flops that share clk. It takes a target word over a
//  valid/ready request and derives legal per-bit S/R excitation from it: set, reset or hold, never S=R=1.
//  It pulses s_out/r_out for one cycle, reads the bank back through q_in, retries on mismatch and
//  reports done or error. It is the drive side of the bank; the SR bank is the receiver.
// PARAMETERS
//  WIDTH      8  number of SR flip-flops driven
//  MAX_RETRY  3  re-drive attempts after the first failed check (0 = no retry)
//  SETTLE     1  WAIT cycles between a drive pulse and the read-back compare (must be >= 1)
// PORTS
//  clk          in   1          clock, rising edge
//  rst          in   1          reset, synchronous, active-low
//  req_valid    in   1          request present
//  req_ready    out  1          controller can accept a request
//  req_data     in   WIDTH      target word for the bank
//  s_out        out  WIDTH      per-bit set drive to bank s inputs
//  r_out        out  WIDTH      per-bit reset drive to bank r inputs
//  q_in         in   WIDTH      bank q read-back
//  rsp_valid    out  1          one-cycle completion pulse
//  rsp_err      out  1          valid with rsp_valid: 1 = q_in != target after the last attempt
//  rsp_retries  out  RW         valid with rsp_valid: re-drives used; RW = max(1,$clog2(MAX_RETRY+1))
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE; s_out, r_out, rsp_valid, rsp_err, rsp_retries, retry count,
//    WAIT counter and target register all 0; req_ready=0 while rst=0. A request in flight is dropped
//    and gets no response.
//  - FSM states IDLE, DRIVE, WAIT, RESP. All outputs are registered or decoded from state.
//  - IDLE: req_ready=1. At a posedge with req_valid=1, latch req_data into tgt, clear retry count,
//    go to DRIVE. req_ready=0 in every other state; req_valid is ignored there.
//  - DRIVE (exactly 1 cycle): s_out = tgt & ~q_in, r_out = ~tgt & q_in, using q_in sampled in this cycle.
//    Bits already equal are held (s=r=0). Then go to WAIT with the counter loaded to SETTLE.
//  - Outside DRIVE, s_out = r_out = 0. Invariant in all cycles: (s_out & r_out) == 0.
//  - WAIT: lasts SETTLE cycles. In the last WAIT cycle compare q_in with tgt:
//    - equal -> RESP, err=0;
//    - unequal and retry count < MAX_RETRY -> increment retry count, go to DRIVE;
//    - unequal and retry count == MAX_RETRY -> RESP, err=1.
//  - RESP (1 cycle): rsp_valid=1, rsp_err and rsp_retries held stable, then IDLE.
//    rsp_err/rsp_retries hold their values until the next RESP or reset.
//  - Latency: the accept edge falls in cycle A (IDLE, valid&ready).
//    - DRIVE in cycle A+1; rsp_valid in cycle A+2+SETTLE when no retry is needed.
//    - Each retry adds 1+SETTLE cycles.
//    - Back-to-back requests: req_ready returns 1 in the cycle after RESP.
//  - Width rules: the retry counter saturates at MAX_RETRY and never wraps. The WAIT counter is
//    $clog2(SETTLE+1) bits.
// TESTING  (WIDTH=8, MAX_RETRY=3, SETTLE=1; bench includes an 8-bit SR bank model)
//  1 rst=0 for 3 cycles with req_valid=1 -> s_out=r_out=0, rsp_valid=0, req_ready=0;
//    req_ready=1 in the first cycle after rst=1.
//  2 bank=0x00, write 0xA5 -> DRIVE at A+1 with s_out=0xA5, r_out=0x00; rsp_valid at A+3,
//    err=0, retries=0; q=0xA5.
//  3 bank=0xF0, write 0x3C -> s_out=0x0C, r_out=0xC0; s_out&r_out==0 asserted every cycle; rsp err=0.
//  4 bank=0x5A, write 0x5A -> DRIVE cycle s_out=r_out=0x00; rsp_valid at A+3, err=0.
//  5 bank bit0 stuck at 0, write 0x01 -> 4 DRIVE pulses (s_out=0x01 each); rsp_valid at A+9,
//    err=1, retries=3.
//  6 rst=0 during WAIT -> next cycle IDLE, outputs 0, no rsp_valid; then write 0xFF with req_valid
//    held during the busy period -> single accept, rsp err=0.

Source files
------------

// File: rtl/sr_bank_writer.sv
// sr_bank_writer: write controller for a bank of WIDTH SR flip-flops.
// It accepts a target word, drives legal per-bit set/reset pulses (never
// S=R=1), and reads the bank back through q_in. On a mismatch it re-drives up
// to MAX_RETRY times. It then reports completion with an error flag and the
// number of re-drives used.
module sr_bank_writer #(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3,
    parameter int SETTLE    = 1,
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1),
    localparam int CW = (SETTLE <= 1) ? 1 : $clog2(SETTLE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] s_out,
    output logic [WIDTH-1:0] r_out,
    input  logic [WIDTH-1:0] q_in,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [RW-1:0]    rsp_retries
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] tgt;
    logic [RW-1:0]    retry_cnt;
    logic [CW-1:0]    wait_cnt;

    // Ready is decoded from state and forced low while reset is asserted.
    assign req_ready = rst && (state == IDLE);

    // Controller FSM. All outputs except req_ready are registered here.
    // NOTE: every register in this block uses non-blocking assignments, so
    // each one reads the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            tgt         <= '0;
            retry_cnt   <= '0;
            wait_cnt    <= '0;
            s_out       <= '0;
            r_out       <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_retries <= '0;
        end else begin
            // Drive pulses and the response strobe last one cycle unless
            // they are re-armed below.
            s_out     <= '0;
            r_out     <= '0;
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tgt       <= req_data;
                        retry_cnt <= '0;
                        // The bank only moves when it is driven, and it is
                        // idle here. So q_in at this edge equals q_in
                        // throughout the DRIVE cycle that follows.
                        s_out     <= req_data & ~q_in;
                        r_out     <= ~req_data & q_in;
                        state     <= DRIVE;
                    end
                end

                DRIVE: begin
                    wait_cnt <= CW'(SETTLE);
                    state    <= WAIT;
                end

                WAIT: begin
                    if (wait_cnt > CW'(1)) begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end else begin
                        wait_cnt <= '0;
                        if (q_in == tgt) begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b0;
                            rsp_retries <= retry_cnt;
                            state       <= RESP;
                        end else if (retry_cnt < RW'(MAX_RETRY)) begin
                            // Re-drive only the bits that still differ.
                            // Equal bits are held with s=r=0.
                            retry_cnt <= retry_cnt + RW'(1);
                            s_out     <= tgt & ~q_in;
                            r_out     <= ~tgt & q_in;
                            state     <= DRIVE;
                        end else begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_retries <= retry_cnt;
                            state       <= RESP;
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
